// File: rtl/conv_pkg.sv
// Shared widths, sign-aware types and tap helper for the 3x3 convolution MAC.
package conv_pkg;
  localparam int PIX_W    = 8;
  localparam int WGT_W    = 8;
  localparam int TAP_W    = 24;
  localparam int NUM_TAPS = 9;
  localparam int PROD_W   = 17;
  localparam int ROW_W    = 19;
  localparam int SUM_W    = 20;

  typedef logic signed [WGT_W-1:0]  wgt_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ROW_W-1:0]  row_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  // Column 0 is the oldest pixel in the top byte of the tap word.
  function automatic logic [PIX_W-1:0] tap_pixel(input logic [TAP_W-1:0] tap, input int col);
    return tap[(2-col)*PIX_W +: PIX_W];
  endfunction
endpackage

// File: rtl/conv_res_fifo.sv
// Synchronous result FIFO with occupancy count; head reads as zero when empty.
module conv_res_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop, w_do_push;

  assign w_do_pop  = pop & (r_count != '0);
  assign w_do_push = push & ((r_count != CW'(DEPTH)) | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push && !clr) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign valid = (r_count != '0);
  assign dout  = valid ? r_mem[r_rd_ptr] : '0;
  assign count = r_count;
endmodule

// File: rtl/conv3x3_mac.sv
// Two-stage 3x3 signed-weight MAC feeding a credit-guarded result FIFO.
// Build option CONV_RELU_EN clamps negative totals to zero before queuing.
module conv3x3_mac #(
  parameter int FIFO_DEPTH = 4,
  parameter int SUM_W      = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      w_load_en,
  input  logic                      w_valid,
  input  logic [31:0]               w_data,
  output logic                      w_ready,
  output logic                      weights_ok,
  input  logic                      alu_en,
  input  logic [conv_pkg::TAP_W-1:0] x_reg1,
  input  logic [conv_pkg::TAP_W-1:0] x_reg2,
  input  logic [conv_pkg::TAP_W-1:0] x_reg3,
  output logic [SUM_W-1:0]          res_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      stall,
  output logic                      overflow
);
  import conv_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wgt_t       r_wgt [NUM_TAPS];
  logic [1:0] r_wcnt;
  logic       r_weights_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_TAPS; i++) r_wgt[i] <= '0;
      r_wcnt       <= 2'd0;
      r_weights_ok <= 1'b0;
    end else if (w_valid && w_load_en) begin
      case (r_wcnt)
        2'd0: begin
          for (int i = 0; i < 4; i++) r_wgt[i] <= w_data[8*i +: 8];
          r_weights_ok <= 1'b0;
          r_wcnt       <= 2'd1;
        end
        2'd1: begin
          for (int i = 0; i < 4; i++) r_wgt[4+i] <= w_data[8*i +: 8];
          r_wcnt <= 2'd2;
        end
        default: begin
          r_wgt[8]     <= w_data[7:0];
          r_wcnt       <= 2'd0;
          r_weights_ok <= 1'b1;
        end
      endcase
    end
  end

  prod_t w_prod [NUM_TAPS];
  prod_t r_prod [NUM_TAPS];
  row_t  w_row [3];
  row_t  r_row [3];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_mul
      logic [TAP_W-1:0] w_tap;
      assign w_tap = (gi < 3) ? x_reg1 : (gi < 6) ? x_reg2 : x_reg3;
      assign w_prod[gi] = prod_t'($signed({1'b0, tap_pixel(w_tap, gi % 3)})) * prod_t'(r_wgt[gi]);
    end
    for (gi = 0; gi < 3; gi++) begin : g_row
      assign w_row[gi] = row_t'(r_prod[3*gi]) + row_t'(r_prod[3*gi+1]) + row_t'(r_prod[3*gi+2]);
    end
  endgenerate

  logic          r_s1_valid, r_s2_valid, r_overflow;
  logic          w_accept;
  sum_t          w_total, w_push_data;
  logic [CW-1:0] w_fifo_count;
  logic [CW:0]   w_credit;

  assign w_accept = alu_en & ~stall & ~clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_overflow <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) r_prod[i] <= '0;
      for (int i = 0; i < 3; i++) r_row[i] <= '0;
    end else begin
      if (clr) begin
        r_s1_valid <= 1'b0;
        r_s2_valid <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        r_s1_valid <= w_accept;
        r_s2_valid <= r_s1_valid;
        if (alu_en && stall) r_overflow <= 1'b1;
      end
      if (w_accept)   for (int i = 0; i < NUM_TAPS; i++) r_prod[i] <= w_prod[i];
      if (r_s1_valid) for (int i = 0; i < 3; i++) r_row[i] <= w_row[i];
    end
  end

  assign w_total = sum_t'(r_row[0]) + sum_t'(r_row[1]) + sum_t'(r_row[2]);

`ifdef CONV_RELU_EN
  assign w_push_data = w_total[$bits(sum_t)-1] ? '0 : w_total;
`else
  assign w_push_data = w_total;
`endif

  conv_res_fifo #(
    .WIDTH (SUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (r_s2_valid),
    .din   (w_push_data),
    .pop   (res_ready),
    .dout  (res_data),
    .valid (res_valid),
    .count (w_fifo_count)
  );

  // Credits count every sample already committed to reach the FIFO.
  assign w_credit   = {1'b0, w_fifo_count} + (CW+1)'(r_s1_valid) + (CW+1)'(r_s2_valid);
  assign stall      = (w_credit >= (CW+1)'(FIFO_DEPTH));
  assign overflow   = r_overflow;
  assign w_ready    = 1'b1;
  assign weights_ok = r_weights_ok;
endmodule

// File: tb/tb_conv3x3_mac.sv
// Directed, table-driven bench for conv3x3_mac (default or CONV_RELU_EN build).
module tb_conv3x3_mac;
  logic        clk = 1'b0;
  logic        rst, clr, w_load_en, w_valid, w_ready, weights_ok;
  logic [31:0] w_data;
  logic        alu_en;
  logic [23:0] x_reg1, x_reg2, x_reg3;
  logic [19:0] res_data;
  logic        res_valid, res_ready, stall, overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conv3x3_mac #(.FIFO_DEPTH(4), .SUM_W(20)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .w_load_en(w_load_en), .w_valid(w_valid), .w_data(w_data),
    .w_ready(w_ready), .weights_ok(weights_ok),
    .alu_en(alu_en), .x_reg1(x_reg1), .x_reg2(x_reg2), .x_reg3(x_reg3),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .stall(stall), .overflow(overflow)
  );

  typedef struct {
    string       name;
    logic [31:0] w0, w1, w2;
    logic [23:0] x1, x2, x3;
    logic [19:0] expv;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] relu(input logic [19:0] v);
`ifdef CONV_RELU_EN
    return v[19] ? 20'h0 : v;
`else
    return v;
`endif
  endfunction

  task automatic load_w(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    w_load_en = 1'b1; w_valid = 1'b1; w_data = a;
    tick();
    check("wok_drop_first_word", {31'b0, weights_ok}, 32'd0);
    w_data = b;
    tick();
    w_data = c;
    tick();
    check("wok_set_after_load", {31'b0, weights_ok}, 32'd1);
    w_load_en = 1'b0; w_valid = 1'b0; w_data = '0;
  endtask

  task automatic sample(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    alu_en = 1'b1; x_reg1 = a; x_reg2 = b; x_reg3 = c;
    tick();
    alu_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"basic",   32'h01010101, 32'h01010101, 32'h00000001, 24'h010203, 24'h040506, 24'h070809, 20'h0002D};
    vecs[1] = '{"neg",     32'hFFFFFFFF, 32'hFFFFFFFF, 32'h000000FF, 24'h010203, 24'h040506, 24'h070809, 20'hFFFD3};
    vecs[2] = '{"min",     32'h80808080, 32'h80808080, 32'h00000080, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 20'hB8480};
    vecs[3] = '{"mapping", 32'h04030201, 32'h08070605, 32'h00000009, 24'h010203, 24'h040506, 24'h070809, 20'h0011D};
    vecs[4] = '{"mixed",   32'h7F80FF02, 32'h00000000, 32'hABCDEF03, 24'h0A0B0C, 24'h800000, 24'h0000FF, 20'h03C86};
    vecs[5] = '{"max",     32'h7F7F7F7F, 32'h7F7F7F7F, 32'h0000007F, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 20'h47289};

    rst = 1'b0; clr = 1'b0; w_load_en = 1'b0; w_valid = 1'b0; w_data = '0;
    alu_en = 1'b0; x_reg1 = '0; x_reg2 = '0; x_reg3 = '0; res_ready = 1'b0;
    tick(); tick();
    check("rst_res_data", {12'b0, res_data}, 32'd0);
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_w_ready", {31'b0, w_ready}, 32'd1);
    check("rst_weights_ok", {31'b0, weights_ok}, 32'd0);
    rst = 1'b1;
    tick();

    // Table-driven single windows: latency, value, hold under backpressure, pop.
    for (int i = 0; i < 6; i++) begin
      load_w(vecs[i].w0, vecs[i].w1, vecs[i].w2);
      sample(vecs[i].x1, vecs[i].x2, vecs[i].x3);
      check({vecs[i].name, "_lat_e"}, {31'b0, res_valid}, 32'd0);
      tick();
      check({vecs[i].name, "_lat_e1"}, {31'b0, res_valid}, 32'd0);
      tick();
      check({vecs[i].name, "_valid"}, {31'b0, res_valid}, 32'd1);
      check({vecs[i].name, "_data"}, {12'b0, res_data}, {12'b0, relu(vecs[i].expv)});
      $display("vec %s: res_data=%h", vecs[i].name, res_data);
      tick();
      check({vecs[i].name, "_hold"}, {12'b0, res_data}, {12'b0, relu(vecs[i].expv)});
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check({vecs[i].name, "_popped"}, {31'b0, res_valid}, 32'd0);
    end

    // Backpressure: four samples fill the credits, fifth is dropped.
    load_w(32'h01010101, 32'h01010101, 32'h00000001);
    check("bp_ovf_init", {31'b0, overflow}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      alu_en = 1'b1; x_reg1 = {8'(i), 16'h0}; x_reg2 = '0; x_reg3 = '0;
      check($sformatf("bp_stall_before_%0d", i), {31'b0, stall}, (i == 5) ? 32'd1 : 32'd0);
      tick();
    end
    alu_en = 1'b0;
    check("bp_overflow_set", {31'b0, overflow}, 32'd1);
    tick(); tick();
    check("bp_stall_full", {31'b0, stall}, 32'd1);
    res_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      check($sformatf("bp_drain_valid_%0d", j), {31'b0, res_valid}, 32'd1);
      check($sformatf("bp_drain_data_%0d", j), {12'b0, res_data}, j);
      $display("drain %0d: res_data=%h", j, res_data);
      tick();
    end
    res_ready = 1'b0;
    check("bp_empty", {31'b0, res_valid}, 32'd0);
    check("bp_stall_clear", {31'b0, stall}, 32'd0);
    check("bp_overflow_sticky", {31'b0, overflow}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_overflow", {31'b0, overflow}, 32'd0);

    // Streaming: eight back-to-back windows with the consumer always ready.
    res_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      alu_en = (t < 8); x_reg1 = {8'(t + 1), 16'h0};
      check($sformatf("st_stall_%0d", t), {31'b0, stall}, 32'd0);
      if (t >= 3 && t <= 10) begin
        check($sformatf("st_valid_%0d", t), {31'b0, res_valid}, 32'd1);
        check($sformatf("st_data_%0d", t), {12'b0, res_data}, t - 2);
        $display("stream %0d: res_data=%h", t - 2, res_data);
      end else begin
        check($sformatf("st_idle_%0d", t), {31'b0, res_valid}, 32'd0);
      end
      tick();
    end
    alu_en = 1'b0; res_ready = 1'b0;

    // Asynchronous reset with two results queued.
    sample({8'd1, 16'h0}, 24'h0, 24'h0);
    sample({8'd2, 16'h0}, 24'h0, 24'h0);
    tick(); tick();
    check("mr_queued", {31'b0, res_valid}, 32'd1);
    #3 rst = 1'b0;
    #1;
    check("mr_res_valid", {31'b0, res_valid}, 32'd0);
    check("mr_res_data", {12'b0, res_data}, 32'd0);
    check("mr_weights_ok", {31'b0, weights_ok}, 32'd0);
    check("mr_stall", {31'b0, stall}, 32'd0);
    check("mr_w_ready", {31'b0, w_ready}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    sample(24'h010203, 24'h040506, 24'h070809);
    tick(); tick();
    check("mr_zero_wgt_valid", {31'b0, res_valid}, 32'd1);
    check("mr_zero_wgt_data", {12'b0, res_data}, 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Clear during traffic: FIFO and in-flight samples dropped, weights kept.
    load_w(32'h01010101, 32'h01010101, 32'h00000001);
    sample(24'h010203, 24'h040506, 24'h070809);
    sample(24'h010203, 24'h040506, 24'h070809);
    sample(24'h010203, 24'h040506, 24'h070809);
    check("clr_pre_valid", {31'b0, res_valid}, 32'd1);
    clr = 1'b1; alu_en = 1'b1;
    tick();
    clr = 1'b0; alu_en = 1'b0;
    check("clr_empty", {31'b0, res_valid}, 32'd0);
    check("clr_stall", {31'b0, stall}, 32'd0);
    tick(); tick(); tick();
    check("clr_no_late", {31'b0, res_valid}, 32'd0);
    check("clr_wok_kept", {31'b0, weights_ok}, 32'd1);
    sample(24'h010203, 24'h040506, 24'h070809);
    tick(); tick();
    check("clr_wgt_kept_valid", {31'b0, res_valid}, 32'd1);
    check("clr_wgt_kept_data", {12'b0, res_data}, 32'h2D);
    $display("post-clear: res_data=%h", res_data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
